sram_mem_controller: RTL

Multi-cycle controller that sits between the pipeline's MEM stage and an external 16-bit-wide SRAM, replacing the single-cycle word data memory. It translates each 32-bit word load or store into two sequenced half-word SRAM accesses, each with a programmable number of wait cycles. While an access is in flight it deasserts `ready`; the hazard/freeze logic uses this to stall every pipeline register.

---
 rtl/sram_mem_controller_pkg.sv | 33 +++
 rtl/sram_mem_controller_phase_counter.sv | 40 ++++
 rtl/sram_mem_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_pkg.sv
//==============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and defaults for the SRAM memory controller:
//            FSM state encoding, request op encoding, default base address.
// Ports    : (package, none)
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_ctrl_pkg;

  // Controller sequencing: one low half-word phase, one high half-word
  // phase, then a single-cycle completion state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Latched request kind.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Byte address that maps onto SRAM word 0.
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

endpackage

`default_nettype wire

// File: rtl/sram_mem_controller_phase_counter.sv
//==============================================================================
// Module   : phase_counter
// Purpose  : Wait-cycle counter for one half-word SRAM phase. Counts
//            0..WAIT_CYCLES-1 while start is high and wraps to 0, so that
//            back-to-back phases each get the full length.
// Ports    : clk   - rising-edge clock
//            rst   - synchronous active-high reset
//            start - run enable; counter is held at 0 while low
//            count - current cycle within the phase
//            last  - high on the final cycle of the phase
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module phase_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] count,
  output logic       last
);

  assign last = (count == 4'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (!start || last) begin
      count <= 4'd0;
    end else begin
      count <= count + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_mem_controller.sv
//==============================================================================
// Module   : sram_mem_controller
// Purpose  : Turns each 32-bit word load/store from the MEM stage into two
//            sequenced 16-bit SRAM accesses (low half, then high half), each
//            lasting WAIT_CYCLES cycles. ready drops while an access is in
//            flight so the pipeline freezes.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            MEMread, MEMwrite     - load / store request
//            address, data         - byte address, store data
//            MEM_result            - registered load data
//            ready                 - low means freeze the pipeline
//            sram_addr             - half-word address to SRAM
//            sram_dq_out/_in/_oe   - data pad out, in, output enable
//            sram_we_n             - active-low write strobe
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEMread,
  input  logic               MEMwrite,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  output logic [31:0]        MEM_result,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  state_t             state;
  op_t                op;
  logic [SRAM_AW-2:0] word_idx;
  logic [31:0]        wdata;
  logic [15:0]        lo_half;
  logic [3:0]         count;
  logic               last;
  logic               run;
  logic               req;
  logic [SRAM_AW-2:0] req_index;

  assign req = MEMread | MEMwrite;

  // Out-of-range addresses simply wrap: the word index is truncated.
  assign req_index = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

  assign ready = ((state == IDLE) && !req) || (state == DONE);

  assign run = (state == LO) || (state == HI);

  phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_counter (
    .clk  (clk),
    .rst  (rst),
    .start(run),
    .count(count),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op          <= OP_RD;
      word_idx    <= '0;
      wdata       <= 32'd0;
      lo_half     <= 16'd0;
      MEM_result  <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Write wins when both requests are raised together.
            op          <= MEMwrite ? OP_WR : OP_RD;
            word_idx    <= req_index;
            wdata       <= data;
            sram_addr   <= {req_index, 1'b0};
            sram_dq_out <= data[15:0];
            sram_dq_oe  <= MEMwrite;
            sram_we_n   <= !MEMwrite;
            state       <= LO;
          end
        end
        LO: begin
          if (last) begin
            if (op == OP_RD) begin
              lo_half <= sram_dq_in;
            end
            sram_addr   <= {word_idx, 1'b1};
            sram_dq_out <= wdata[31:16];
            sram_we_n   <= (op != OP_WR);
            state       <= HI;
          end else if (count == 4'(WAIT_CYCLES - 2)) begin
            // Release the strobe one cycle early for address/data hold.
            sram_we_n <= 1'b1;
          end
        end
        HI: begin
          if (last) begin
            if (op == OP_RD) begin
              MEM_result <= {sram_dq_in, lo_half};
            end
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            state      <= DONE;
          end else if (count == 4'(WAIT_CYCLES - 2)) begin
            sram_we_n <= 1'b1;
          end
        end
        DONE: begin
          // Requests are ignored here: the pipeline advances on this edge.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
